pipe_stall_ctrl: RTL and testbench

- Central pipeline control unit for the 5-stage RISC-V core; produces the 6-bit stall vector and the flush strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and sequences multi-cycle EX operations and data-memory wait states.
- Maintains a stall-cycle performance counter.
- Register-side convention: a stage register holds while its own stall bit is 1; it loads a bubble when its own bit is 1 and the next bit is 0.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_det.sv | 27 ++
 rtl/pipe_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the core pipeline control block.
// Holds the stall-vector codes, the controller FSM states and the load writeback select.
// Contains only constants and types; there is no logic, latency or backpressure here.
package pipe_ctrl_pkg;

  // Stall vectors are prefix-shaped: every stage upstream of the bubble holds as well.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Writeback select value that marks a load (result comes from data memory).
  localparam logic [1:0] WB_MEM = 2'b00;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    EX_BUSY  = 2'b01,
    MEM_WAIT = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard detector: the ID instruction reads a register that a load in EX writes.
// Purely combinational, zero latency.
// Has no flow control; the caller masks the result while deeper stalls or flushes are active.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_RegWEn,
  input  logic [1:0] ex_WBSel,
  output logic       lu_hazard
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign ex_is_load = ex_RegWEn & (ex_WBSel == WB_MEM) & (ex_rd != 5'd0);
  assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
  assign lu_hazard  = ex_is_load & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline control: stall vector, flush strobes, EX multi-cycle and dmem wait sequencing.
// Outputs are combinational from registered state plus current inputs (same-cycle response).
// Deepest stall wins (MEM > EX > ID); a redirect is held pending until EX/MEM is free to move.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int EX_LAT      = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWEn,
  input  logic [1:0]       ex_WBSel,
  input  logic             ex_PCSel,
  input  logic             ex_mc_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [5:0]       stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  // ex_cnt holds the number of EX stall cycles still owed after the current one.
  localparam int EXC_W   = (EX_LAT > 1) ? $clog2(EX_LAT + 1) : 1;
  localparam int EX_LOAD = (EX_LAT > 2) ? (EX_LAT - 2) : 0;
  localparam bit EX_EN   = (EX_LAT > 1);
  localparam int MC_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [EXC_W-1:0] EX_LOAD_V = EXC_W'(EX_LOAD);
  localparam logic [MC_W-1:0]  TMO_LAST  = MC_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [EXC_W-1:0]  ex_cnt;
  logic [EXC_W-1:0]  ex_cnt_nxt;
  logic [MC_W-1:0]   mem_cnt;
  logic [MC_W-1:0]   mem_cnt_nxt;
  logic              flush_pend;
  logic              mem_err_q;
  logic [CNT_W-1:0]  perf_q;

  logic              lu_hazard;
  logic              mem_wait;
  logic              mem_tmo;
  logic              mem_stall;
  logic              ex_seq;
  logic              ex_start;
  logic              ex_stall;
  logic              stall_ex_mem;
  logic              flush_req;
  logic              flush_now;
  logic              lu_stall;
  logic [5:0]        stall_code;

  pipe_hazard_det u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_RegWEn  (ex_RegWEn),
    .ex_WBSel   (ex_WBSel),
    .lu_hazard  (lu_hazard)
  );

  // FSM state register; any reset abandons an in-flight EX or MEM sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Stall arbitration, flush timing, counter next values and FSM next state.
  always_comb begin
    mem_wait     = mem_req & ~mem_ready;
    // The wait cycle that would be number MEM_TIMEOUT is released instead of stalled.
    mem_tmo      = mem_wait & (mem_cnt == TMO_LAST);
    mem_stall    = mem_wait & ~mem_tmo;

    // An EX sequence is live in EX_BUSY, or frozen underneath a MEM wait.
    ex_seq       = (state == EX_BUSY) | ((state == MEM_WAIT) & (ex_cnt != '0));
    ex_start     = EX_EN & ex_mc_start & ~ex_seq & ~mem_stall;
    ex_stall     = ~mem_stall & (ex_seq | ex_start);
    stall_ex_mem = mem_stall | ex_stall;

    // A redirect cannot kill IF/ID or ID/EX while those stages are frozen.
    flush_req    = ex_PCSel | flush_pend;
    flush_now    = flush_req & ~stall_ex_mem;
    // The ID instruction is discarded by a flush, so its hazard is moot.
    lu_stall     = lu_hazard & ~stall_ex_mem & ~flush_now;

    stall_code = STALL_NONE;
    if (mem_stall) begin
      stall_code = STALL_MEM;
    end else if (ex_stall) begin
      stall_code = STALL_EX;
    end else if (lu_stall) begin
      stall_code = STALL_ID;
    end

    // The EX countdown only advances when EX/MEM is allowed to move.
    ex_cnt_nxt = ex_cnt;
    if (!mem_stall) begin
      if (ex_start) begin
        ex_cnt_nxt = EX_LOAD_V;
      end else if (ex_cnt != '0) begin
        ex_cnt_nxt = ex_cnt - EXC_W'(1);
      end
    end

    mem_cnt_nxt = mem_stall ? (mem_cnt + MC_W'(1)) : '0;

    state_nxt = RUN;
    if (mem_stall) begin
      state_nxt = MEM_WAIT;
    end else if (ex_cnt_nxt != '0) begin
      state_nxt = EX_BUSY;
    end
  end

  // Counters, pending flush, sticky timeout flag and the stall performance counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_cnt     <= '0;
      mem_cnt    <= '0;
      flush_pend <= 1'b0;
      mem_err_q  <= 1'b0;
      perf_q     <= '0;
    end else begin
      ex_cnt     <= ex_cnt_nxt;
      mem_cnt    <= mem_cnt_nxt;
      flush_pend <= flush_req & stall_ex_mem;
      if (mem_tmo) begin
        mem_err_q <= 1'b1;
      end
      if (stall_code[0]) begin
        perf_q <= perf_q + CNT_W'(1);
      end
    end
  end

  assign stall          = rst_n ? stall_code : STALL_NONE;
  assign flush_if_id    = rst_n & flush_now;
  assign flush_id_ex    = rst_n & flush_now;
  assign ex_busy        = rst_n & (stall_code == STALL_EX);
  assign mem_err        = rst_n & mem_err_q;
  assign perf_stall_cnt = rst_n ? perf_q : '0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int EX_LAT      = 4;
  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_W       = 16;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_RegWEn;
  logic [1:0]       ex_WBSel;
  logic             ex_PCSel;
  logic             ex_mc_start;
  logic             mem_req;
  logic             mem_ready;
  logic [5:0]       stall;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             ex_busy;
  logic             mem_err;
  logic [CNT_W-1:0] perf_stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stall_ctrl #(
    .EX_LAT      (EX_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_RegWEn      (ex_RegWEn),
    .ex_WBSel       (ex_WBSel),
    .ex_PCSel       (ex_PCSel),
    .ex_mc_start    (ex_mc_start),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .stall          (stall),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .ex_busy        (ex_busy),
    .mem_err        (mem_err),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_RegWEn = 1'b0; ex_WBSel = 2'b11; ex_PCSel = 1'b0;
    ex_mc_start = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_rd = 5'd5; ex_RegWEn = 1'b1; ex_WBSel = 2'b00; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: remaining EX stall cycles, consecutive wait count, pending redirect.
  int               m_ex_left;
  int               m_wait;
  bit               m_err;
  bit               m_pend;
  logic [CNT_W-1:0] m_cnt;
  logic [5:0]       e_stall;
  bit               e_flush;
  bit               e_mstall;
  bit               e_tmo;
  bit               e_start;
  bit               e_s3;
  bit               e_freq;

  task automatic model_reset();
    m_ex_left = 0; m_wait = 0; m_err = 0; m_pend = 0; m_cnt = '0;
  endtask

  task automatic model_eval();
    bit hz;
    bit estall;
    bit waiting;
    waiting  = mem_req && !mem_ready;
    e_tmo    = waiting && (m_wait == MEM_TIMEOUT - 1);
    e_mstall = waiting && !e_tmo;
    e_start  = (EX_LAT > 1) && ex_mc_start && (m_ex_left == 0) && !e_mstall;
    estall   = !e_mstall && (m_ex_left > 0 || e_start);
    e_s3     = e_mstall || estall;
    e_freq   = ex_PCSel || m_pend;
    e_flush  = e_freq && !e_s3;
    hz = ex_RegWEn && ex_WBSel == 2'b00 && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (e_mstall)              e_stall = S_MEM;
    else if (estall)           e_stall = S_EX;
    else if (hz && !e_flush)   e_stall = S_ID;
    else                       e_stall = S_NONE;
  endtask

  task automatic model_commit();
    m_wait = e_mstall ? m_wait + 1 : 0;
    if (e_tmo) m_err = 1;
    if (!e_mstall) begin
      if (e_start) m_ex_left = EX_LAT - 2;
      else if (m_ex_left > 0) m_ex_left = m_ex_left - 1;
    end
    m_pend = e_freq && e_s3;
    if (e_stall[0]) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    set_load_use();
    mem_req = 1'b1;
    ex_PCSel = 1'b1;
    ex_mc_start = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if ({stall, flush_if_id, flush_id_ex, ex_busy, mem_err} !== 10'd0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0", {stall, flush_if_id, flush_id_ex, ex_busy, mem_err});
    end
    total++;
    if (perf_stall_cnt !== '0) begin
      bad++; $display("FAIL reset_perf got=%0d want=0", perf_stall_cnt);
    end
    tick();
    reset_dut();
    @(negedge clk);
    total++;
    if (stall !== S_NONE || perf_stall_cnt !== '0) begin
      bad++; $display("FAIL reset_idle stall=%b perf=%0d want 0/0", stall, perf_stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    reset_dut();
    set_load_use();
    @(negedge clk);
    total++;
    if (stall !== S_ID || flush_if_id !== 1'b0) begin
      bad++; $display("FAIL lu_stall got=%b flush=%b want=%b/0", stall, flush_if_id, S_ID);
    end
    tick();
    ex_RegWEn = 1'b0;  // bubble now in EX
    @(negedge clk);
    total++;
    if (stall !== S_NONE || perf_stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_release stall=%b perf=%0d want 0/1", stall, perf_stall_cnt);
    end
    tick();
    ex_RegWEn = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    total++;
    if (stall !== S_NONE) begin
      bad++; $display("FAIL lu_x0 got=%b want=%b", stall, S_NONE);
    end
    tick();
    ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_use_rs1 = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== S_ID) begin
      bad++; $display("FAIL lu_rs2 got=%b want=%b", stall, S_ID);
    end
    tick();
    ex_WBSel = 2'b01;
    @(negedge clk);
    total++;
    if (stall !== S_NONE) begin
      bad++; $display("FAIL lu_not_load got=%b want=%b", stall, S_NONE);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_ex_multi();
    reset_dut();
    ex_mc_start = 1'b1;
    for (int i = 0; i < EX_LAT; i++) begin
      @(negedge clk);
      total++;
      if (stall !== ((i < EX_LAT - 1) ? S_EX : S_NONE) || ex_busy !== (i < EX_LAT - 1)) begin
        bad++; $display("FAIL ex_seq cyc=%0d stall=%b busy=%b", i, stall, ex_busy);
      end
      tick();
      ex_mc_start = 1'b0;
    end
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== 16'(EX_LAT - 1)) begin
      bad++; $display("FAIL ex_perf got=%0d want=%0d", perf_stall_cnt, EX_LAT - 1);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [5:0] exp_seq [6];
    int nz;
    reset_dut();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
      total++;
      if (stall !== ((i < 3) ? S_MEM : S_NONE)) begin
        bad++; $display("FAIL mem_wait cyc=%0d got=%b", i, stall);
      end
      tick();
    end
    clear_inputs();
    // EX op starts, then a 2-cycle dmem wait freezes its countdown.
    exp_seq = '{S_EX, S_MEM, S_MEM, S_EX, S_EX, S_NONE};
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      ex_mc_start = (i == 0);
      mem_req     = (i == 1 || i == 2);
      mem_ready   = 1'b0;
      @(negedge clk);
      if (stall != S_NONE) nz++;
      total++;
      if (stall !== exp_seq[i] || ex_busy !== (exp_seq[i] == S_EX)) begin
        bad++; $display("FAIL ex_mem cyc=%0d stall=%b busy=%b want=%b", i, stall, ex_busy, exp_seq[i]);
      end
      tick();
    end
    clear_inputs();
    total++;
    if (nz !== 5) begin
      bad++; $display("FAIL ex_mem_len got=%0d want=5", nz);
    end
  endtask

  task automatic test_flush();
    logic [5:0] exp_s [5];
    reset_dut();
    set_load_use();
    ex_PCSel = 1'b1;
    @(negedge clk);
    total++;
    if ({flush_if_id, flush_id_ex} !== 2'b11 || stall !== S_NONE) begin
      bad++; $display("FAIL flush_lu flush=%b%b stall=%b want 11/0", flush_if_id, flush_id_ex, stall);
    end
    tick();
    clear_inputs();
    exp_s = '{S_EX, S_EX, S_EX, S_NONE, S_NONE};
    for (int i = 0; i < 5; i++) begin
      ex_mc_start = (i == 0);
      ex_PCSel    = (i == 1);
      @(negedge clk);
      total++;
      if (stall !== exp_s[i] || flush_if_id !== (i == 3) || flush_id_ex !== (i == 3)) begin
        bad++; $display("FAIL flush_defer cyc=%0d stall=%b flush=%b%b", i, stall, flush_if_id, flush_id_ex);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int nm;
    reset_dut();
    mem_req = 1'b1;
    nm = 0;
    for (int i = 1; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      if (stall === S_MEM) nm++;
      tick();
    end
    total++;
    if (nm !== MEM_TIMEOUT - 1) begin
      bad++; $display("FAIL tmo_waits got=%0d want=%0d", nm, MEM_TIMEOUT - 1);
    end
    @(negedge clk);
    total++;
    if (stall !== S_NONE || mem_err !== 1'b0) begin
      bad++; $display("FAIL tmo_release stall=%b err=%b want 0/0", stall, mem_err);
    end
    tick();
    @(negedge clk);
    total++;
    if (stall !== S_MEM || mem_err !== 1'b1) begin
      bad++; $display("FAIL tmo_after stall=%b err=%b want %b/1", stall, mem_err, S_MEM);
    end
    tick();
    mem_req = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    total++;
    if (mem_err !== 1'b1) begin
      bad++; $display("FAIL tmo_sticky got=%b want=1", mem_err);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (mem_err !== 1'b0) begin
      bad++; $display("FAIL tmo_clear got=%b want=0", mem_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_ex();
    reset_dut();
    ex_mc_start = 1'b1;
    tick();
    ex_mc_start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, flush_if_id, flush_id_ex, ex_busy, mem_err} !== 10'd0 || perf_stall_cnt !== '0) begin
      bad++; $display("FAIL rst_mid_during stall=%b busy=%b perf=%0d", stall, ex_busy, perf_stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (stall !== S_NONE || ex_busy !== 1'b0 || perf_stall_cnt !== '0) begin
      bad++; $display("FAIL rst_mid_after stall=%b busy=%b perf=%0d want idle", stall, ex_busy, perf_stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    reset_dut();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_RegWEn   = 1'($urandom_range(0, 1));
      ex_WBSel    = 2'($urandom_range(0, 3));
      ex_PCSel    = ($urandom_range(0, 9) == 0);
      ex_mc_start = ($urandom_range(0, 5) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      model_eval();
      @(negedge clk);
      total++;
      if (stall !== e_stall || flush_if_id !== e_flush || flush_id_ex !== e_flush ||
          ex_busy !== (e_stall == S_EX) || mem_err !== m_err || perf_stall_cnt !== m_cnt) begin
        bad++;
        $display("FAIL rand cyc=%0d got s=%b f=%b%b b=%b e=%b p=%0d want s=%b f=%b e=%b p=%0d",
                 c, stall, flush_if_id, flush_id_ex, ex_busy, mem_err, perf_stall_cnt,
                 e_stall, e_flush, m_err, m_cnt);
      end
      model_commit();
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    reset_dut();
    set_load_use();  // held hazard stalls ID every cycle
    repeat (65535) tick();
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_max got=%h want=ffff", perf_stall_cnt);
    end
    tick();
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== 16'h0000) begin
      bad++; $display("FAIL wrap_zero got=%h want=0000", perf_stall_cnt);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_ex_multi();
    test_mem_wait();
    test_flush();
    test_timeout();
    test_reset_mid_ex();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
